// File: rtl/led_level_meter.sv
// Audio level meter: mono mix of the codec sample pair, fast-attack/slow-decay envelope, peak hold, stretched clip, LED bar.
// Latency: data_en at T -> env_out/peak_out/clip at T+3, leds at T+4.
// Backpressure: none; a strobe is accepted on every cycle, including back-to-back.
module led_level_meter #(
    parameter int DECAY_DIV    = 48,
    parameter int DECAY_SHIFT  = 3,
    parameter int HOLD_SAMPLES = 24000,
    parameter int CLIP_SAMPLES = 4800
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        data_en,
    input  logic [17:0] left_in,
    input  logic [17:0] right_in,
    input  logic        freeze,
    output logic [16:0] env_out,
    output logic [16:0] peak_out,
    output logic [7:0]  leds,
    output logic        clip
);

    localparam int DW = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
    localparam int HW = (HOLD_SAMPLES > 0) ? $clog2(HOLD_SAMPLES + 1) : 1;
    localparam int CW = (CLIP_SAMPLES > 0) ? $clog2(CLIP_SAMPLES + 1) : 1;

    // stage 1
    logic [18:0]   sum;
    logic [18:0]   mono_d, mono_q;
    logic          v1_d, v1_q;
    logic          clip1_d, clip1_q;
    // stage 2
    logic [18:0]   abs_mono;
    logic          sat;
    logic [16:0]   mag_d, mag_q;
    logic          v2_d, v2_q;
    logic          clip2_d, clip2_q;
    // stage 3
    logic          tick;
    logic [16:0]   step;
    logic [16:0]   env_d, env_q;
    logic [16:0]   peak_d, peak_q;
    logic [HW-1:0] hold_d, hold_q;
    logic [DW-1:0] dec_cnt_d, dec_cnt_q;
    logic [CW-1:0] clip_cnt_d, clip_cnt_q;
    // output stage
    logic [7:0]    bar, pk;
    logic [7:0]    leds_d, leds_q;

    // Stage 1: sign-extended sum halved to a 19-bit mono sample; flag full-scale inputs.
    always_comb begin
        sum     = {left_in[17], left_in} + {right_in[17], right_in};
        mono_d  = 19'($signed(sum) >>> 1);
        v1_d    = data_en;
        clip1_d = (left_in  == 18'h1FFFF) || (left_in  == 18'h20000) ||
                  (right_in == 18'h1FFFF) || (right_in == 18'h20000);
    end

    // Stage 2: magnitude of mono; only -2^17 overflows 17 bits, and it saturates and counts as a clip.
    always_comb begin
        abs_mono = mono_q[18] ? (~mono_q + 19'd1) : mono_q;
        sat      = abs_mono[18] | abs_mono[17];
        mag_d    = sat ? 17'h1FFFF : abs_mono[16:0];
        v2_d     = v1_q;
        clip2_d  = v1_q & (clip1_q | sat);
    end

    // Stage 3: envelope, decay divider, peak hold and clip stretch; all frozen while freeze is high.
    always_comb begin
        env_d      = env_q;
        peak_d     = peak_q;
        hold_d     = hold_q;
        dec_cnt_d  = dec_cnt_q;
        clip_cnt_d = clip_cnt_q;
        tick       = 1'b0;
        step       = 17'd0;
        if (v2_q && !freeze) begin
            tick      = (dec_cnt_q == DW'(DECAY_DIV - 1));
            dec_cnt_d = tick ? '0 : dec_cnt_q + 1'b1;

            // attack wins over a decay tick landing on the same sample
            if (mag_q >= env_q) begin
                env_d = mag_q;
            end else if (tick) begin
                step  = env_q >> DECAY_SHIFT;
                if (step == 17'd0) begin
                    step = 17'd1;
                end
                env_d = (env_q > step) ? (env_q - step) : 17'd0;
            end

            // once the hold expires the marker follows this sample's envelope
            if (mag_q >= peak_q) begin
                peak_d = mag_q;
                hold_d = HW'(HOLD_SAMPLES);
            end else if (hold_q != '0) begin
                hold_d = hold_q - 1'b1;
            end else begin
                peak_d = env_d;
            end

            if (clip2_q) begin
                clip_cnt_d = CW'(CLIP_SAMPLES);
            end else if (clip_cnt_q != '0) begin
                clip_cnt_d = clip_cnt_q - 1'b1;
            end
        end
    end

    // Output stage: thermometer bar from env plus a single dot at the highest threshold peak reaches.
    always_comb begin
        bar = '0;
        pk  = '0;
        for (int i = 0; i < 8; i++) begin
            bar[i] = (env_q  >= 17'(1 << (9 + i)));
            pk[i]  = (peak_q >= 17'(1 << (9 + i)));
        end
        leds_d = bar | (pk & ~(pk >> 1));
    end

    // All state registers; reset clears everything, discarding samples in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mono_q     <= '0;
            v1_q       <= 1'b0;
            clip1_q    <= 1'b0;
            mag_q      <= '0;
            v2_q       <= 1'b0;
            clip2_q    <= 1'b0;
            env_q      <= '0;
            peak_q     <= '0;
            hold_q     <= '0;
            dec_cnt_q  <= '0;
            clip_cnt_q <= '0;
            leds_q     <= '0;
        end else begin
            mono_q     <= mono_d;
            v1_q       <= v1_d;
            clip1_q    <= clip1_d;
            mag_q      <= mag_d;
            v2_q       <= v2_d;
            clip2_q    <= clip2_d;
            env_q      <= env_d;
            peak_q     <= peak_d;
            hold_q     <= hold_d;
            dec_cnt_q  <= dec_cnt_d;
            clip_cnt_q <= clip_cnt_d;
            leds_q     <= leds_d;
        end
    end

    assign env_out  = env_q;
    assign peak_out = peak_q;
    assign leds     = leds_q;
    assign clip     = (clip_cnt_q != '0);

endmodule

// File: tb/tb_led_level_meter.sv
// Bench for led_level_meter: directed samples, expectations queued at issue time.
// A monitor pops them when a sample reaches the output (T+3 for env/peak/clip, T+4 for leds).
// Non-checkpoint samples still occupy a queue slot so ordering stays aligned.
module tb_led_level_meter;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        data_en;
    logic [17:0] left_in;
    logic [17:0] right_in;
    logic        freeze;
    logic [16:0] env_out;
    logic [16:0] peak_out;
    logic [7:0]  leds;
    logic        clip;

    led_level_meter #(
        .DECAY_DIV    (48),
        .DECAY_SHIFT  (3),
        .HOLD_SAMPLES (24000),
        .CLIP_SAMPLES (4800)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .data_en  (data_en),
        .left_in  (left_in),
        .right_in (right_in),
        .freeze   (freeze),
        .env_out  (env_out),
        .peak_out (peak_out),
        .leds     (leds),
        .clip     (clip)
    );

    always #40 clock = ~clock;

    typedef struct {
        bit          chk;
        logic [16:0] env;
        logic [16:0] peak;
        logic        clip;
        logic [7:0]  leds;
        int          tag;
    } exp_t;

    typedef struct {
        int          k;
        logic [17:0] l;
        logic [17:0] r;
        logic [16:0] env;
        logic [16:0] peak;
        logic        clip;
        logic [7:0]  leds;
    } vec_t;

    exp_t q[$];
    vec_t cp[$];
    exp_t cur;
    exp_t last;
    logic [3:0] sh;
    int checks   = 0;
    int failures = 0;

    task automatic cmp(input string name, input int tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s tag=%0d got=%0h expected=%0h", name, tag, act, exp);
        end
    endtask

    // tracks which cycle a strobed sample reaches stage 3 and the LED register
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) sh <= 4'd0;
        else          sh <= {sh[2:0], data_en};
    end

    // monitor: leds of the previous sample first, then pop the sample now at stage 3
    always @(negedge clock) begin
        if (sh[3] && last.chk) begin
            cmp("leds", last.tag, 32'(leds), 32'(last.leds));
        end
        if (sh[2]) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL queue_underflow got=empty expected=entry");
                last.chk = 1'b0;
            end else begin
                cur = q.pop_front();
                if (cur.chk) begin
                    cmp("env_out",  cur.tag, 32'(env_out),  32'(cur.env));
                    cmp("peak_out", cur.tag, 32'(peak_out), 32'(cur.peak));
                    cmp("clip",     cur.tag, 32'(clip),     32'(cur.clip));
                end
                last = cur;
            end
        end
    end

    task automatic send(input logic [17:0] l, input logic [17:0] r, input bit chk,
                        input logic [16:0] e, input logic [16:0] p, input logic c,
                        input logic [7:0] ld, input int tag);
        exp_t x;
        @(negedge clock);
        left_in  = l;
        right_in = r;
        data_en  = 1'b1;
        x.chk  = chk;
        x.env  = e;
        x.peak = p;
        x.clip = c;
        x.leds = ld;
        x.tag  = tag;
        q.push_back(x);
    endtask

    task automatic idle(input int n);
        @(negedge clock);
        data_en = 1'b0;
        repeat (n - 1) @(negedge clock);
    endtask

    task automatic add_cp(input int k, input logic [17:0] l, input logic [17:0] r,
                          input logic [16:0] e, input logic [16:0] p, input logic c,
                          input logic [7:0] ld);
        vec_t v;
        v.k = k; v.l = l; v.r = r; v.env = e; v.peak = p; v.clip = c; v.leds = ld;
        cp.push_back(v);
    endtask

    // n back-to-back samples; checkpoint samples carry their own inputs, all others are silence
    task automatic run(input int n, input int tag_base);
        vec_t v;
        for (int k = 1; k <= n; k++) begin
            if (cp.size() > 0 && cp[0].k == k) begin
                v = cp.pop_front();
                send(v.l, v.r, 1'b1, v.env, v.peak, v.clip, v.leds, tag_base * 100000 + k);
            end else begin
                send(18'd0, 18'd0, 1'b0, 17'd0, 17'd0, 1'b0, 8'd0, tag_base * 100000 + k);
            end
        end
        idle(6);
    endtask

    task automatic do_reset();
        @(negedge clock);
        data_en = 1'b0;
        reset_n = 1'b0;
        q.delete();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n  = 1'b0;
        data_en  = 1'b0;
        left_in  = 18'd0;
        right_in = 18'd0;
        freeze   = 1'b0;
        last.chk = 1'b0;
        #1;
        cmp("rst_env",  0, 32'(env_out),  32'd0);
        cmp("rst_peak", 0, 32'(peak_out), 32'd0);
        cmp("rst_leds", 0, 32'(leds),     32'd0);
        cmp("rst_clip", 0, 32'(clip),     32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        // attack and latency, then asynchronous reset with a nonzero envelope
        send(18'h10000, 18'h10000, 1'b1, 17'h10000, 17'h10000, 1'b0, 8'hFF, 1);
        idle(6);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        cmp("arst_env",  1, 32'(env_out),  32'd0);
        cmp("arst_peak", 1, 32'(peak_out), 32'd0);
        cmp("arst_leds", 1, 32'(leds),     32'd0);
        cmp("arst_clip", 1, 32'(clip),     32'd0);
        q.delete();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        // decay steps on every 48th sample, peak holds 24000 samples then follows env
        add_cp(1,     18'h10000, 18'h10000, 17'd65536, 17'd65536, 1'b0, 8'hFF);
        add_cp(47,    18'd0, 18'd0, 17'd65536, 17'd65536, 1'b0, 8'hFF);
        add_cp(48,    18'd0, 18'd0, 17'd57344, 17'd65536, 1'b0, 8'hFF);
        add_cp(95,    18'd0, 18'd0, 17'd57344, 17'd65536, 1'b0, 8'hFF);
        add_cp(96,    18'd0, 18'd0, 17'd50176, 17'd65536, 1'b0, 8'hFF);
        add_cp(24001, 18'd0, 18'd0, 17'd0,     17'd65536, 1'b0, 8'h80);
        add_cp(24002, 18'd0, 18'd0, 17'd0,     17'd0,     1'b0, 8'h00);
        run(24002, 2);
        do_reset();

        // mono mix of opposite full-scale inputs, clip stretch, -2^17 saturation
        add_cp(1,    18'h1FFFF, 18'h20000, 17'd1, 17'd1, 1'b1, 8'h00);
        add_cp(4800, 18'd0, 18'd0, 17'd0, 17'd1, 1'b1, 8'h00);
        add_cp(4801, 18'd0, 18'd0, 17'd0, 17'd1, 1'b0, 8'h00);
        add_cp(4802, 18'h20000, 18'h20000, 17'h1FFFF, 17'h1FFFF, 1'b1, 8'hFF);
        run(4802, 3);
        do_reset();

        // peak dot: held peak 40000 over a small envelope of 600
        add_cp(1,    18'd40000, 18'd40000, 17'd40000, 17'd40000, 1'b0, 8'h7F);
        add_cp(6000, 18'd0, 18'd0, 17'd0, 17'd40000, 1'b0, 8'h40);
        add_cp(6001, 18'd600, 18'd600, 17'd600, 17'd40000, 1'b0, 8'h41);
        run(6001, 4);
        do_reset();

        // back-to-back strobes
        add_cp(1, 18'd100, 18'd100, 17'd100, 17'd100, 1'b0, 8'h00);
        add_cp(2, 18'd200, 18'd200, 17'd200, 17'd200, 1'b0, 8'h00);
        add_cp(3, 18'd300, 18'd300, 17'd300, 17'd300, 1'b0, 8'h00);
        add_cp(4, 18'd250, 18'd250, 17'd300, 17'd300, 1'b0, 8'h00);
        add_cp(5, 18'd50,  18'd50,  17'd300, 17'd300, 1'b0, 8'h00);
        run(5, 5);

        // freeze blocks the update; the same input afterwards goes through
        @(negedge clock);
        freeze = 1'b1;
        send(18'd60000, 18'd60000, 1'b1, 17'd300, 17'd300, 1'b0, 8'h00, 601);
        idle(6);
        freeze = 1'b0;
        send(18'd60000, 18'd60000, 1'b1, 17'd60000, 17'd60000, 1'b0, 8'h7F, 602);
        idle(6);

        // reset while a sample is in flight discards it
        send(18'd50000, 18'd50000, 1'b0, 17'd0, 17'd0, 1'b0, 8'h00, 701);
        @(negedge clock);
        data_en = 1'b0;
        reset_n = 1'b0;
        q.delete();
        @(negedge clock);
        reset_n = 1'b1;
        idle(6);
        cmp("flush_env",  7, 32'(env_out),  32'd0);
        cmp("flush_peak", 7, 32'(peak_out), 32'd0);
        cmp("flush_leds", 7, 32'(leds),     32'd0);

        cmp("queue_empty", 0, 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
